muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits (RV32M).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rstControl, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on the CLK rising edge.
REQ-005 The block SHALL have port funct3, input, 3 bits: operation select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-006 The block SHALL have ports A and B, input, 32 bits each: rs1 and rs2 operand values from the register-file read outputs.
REQ-007 The block SHALL have port rdIn, input, 5 bits: destination register tag, captured with the operands.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion strobe.
REQ-010 The block SHALL have port result, output, 32 bits: completed value, destined for the register-file writeBack input.
REQ-011 The block SHALL have port rdOut, output, 5 bits: tag of the completed operation, destined for the register-file rd input.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted at that edge, latching funct3, A, B and rdIn; start in CALC or DONE SHALL be ignored with no effect.
REQ-014 On accept, the operands SHALL be converted to magnitudes per signedness (MULH: both signed; MULHSU: A signed, B unsigned; DIV/REM: both signed; all others unsigned), and the result sign SHALL be recorded.
REQ-015 Normal operations SHALL move IDLE->CALC at the accept edge and perform one radix-2 step per edge, counting 0..31, with a 64-bit shift-add multiply or a restoring divide.
REQ-016 After the 32nd CALC edge, the FSM SHALL enter DONE, with done=1, result and rdOut valid, for exactly one cycle, then return to IDLE; total latency SHALL be done high 32 cycles after the accept edge.
REQ-017 MUL SHALL return product[31:0], and MULH/MULHSU/MULHU SHALL return product[63:32] after 64-bit two's-complement negation when the recorded sign is negative.
REQ-018 DIV/REM SHALL truncate toward zero; the quotient sign SHALL be sign(A) xor sign(B), and the remainder sign SHALL equal sign(A).
REQ-019 Division by zero (B=0) SHALL skip CALC (IDLE->DONE at the accept edge, done high the next cycle) and return quotient 0xFFFFFFFF for DIV/DIVU and remainder = A for REM/REMU.
REQ-020 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL skip CALC and return quotient 0x80000000 and remainder 0.
REQ-021 result and rdOut SHALL hold their last completed values until the next DONE; done SHALL be 0 in IDLE and CALC.
REQ-022 rdIn=0 SHALL still be computed and reported; write suppression for x0 is the register file's responsibility.
REQ-023 A new start SHALL be accepted in the IDLE cycle immediately following DONE, giving back-to-back throughput of one operation per 33 cycles.

Reset
REQ-024 Asserting rstControl SHALL immediately force state IDLE, busy=0, done=0, result=0x00000000, rdOut=0, and iteration counter=0, independent of CLK.
REQ-025 Reset mid-operation SHALL discard the operation, with no later done for it; the first start after reset deassertion SHALL be accepted normally.

Verification
REQ-026 MUL A=7, B=0xFFFFFFFD, rdIn=5 -> busy high for 33 cycles, done high 32 cycles after the accept edge, result=0xFFFFFFEB, rdOut=5.
REQ-027 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIVU 5/0 -> 0xFFFFFFFF with done high one cycle after accept; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-030 start pulsed again during CALC with different operands -> ignored, and the first operation's result is delivered unchanged.
REQ-031 rstControl asserted 10 cycles into a DIV -> busy, done, result and rdOut all 0 immediately (before the next edge), and no done follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock,
// 32 steps per operation, with divide-by-zero and signed overflow resolved at accept.
module muldiv_unit (
  input  logic        CLK,
  input  logic        rstControl,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  rdIn,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rdOut
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic        signed_a, signed_b, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        is_div, div_zero, div_ovf;
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff, div_hi, div_lo;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod, prod_s;
  logic [31:0] quot_s, rem_s, final_res;

  // Operand conditioning at accept time.
  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = signed_a & A[31];
    b_neg    = signed_b & B[31];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    is_div   = funct3[2];
    div_zero = is_div && (B == 32'd0);
    div_ovf  = is_div && !funct3[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  end

  // One iteration: shift-add multiply (hi:lo is product/multiplier) or
  // restoring divide (hi is partial remainder, lo is dividend/quotient).
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_hi   = mul_sum[32:1];
    mul_lo   = {mul_sum[0], lo_q[31:1]};
    div_sh   = {hi_q, lo_q[31]};
    div_ge   = div_sh >= {1'b0, opb_q};
    div_diff = div_sh[31:0] - opb_q;
    div_hi   = div_ge ? div_diff : div_sh[31:0];
    div_lo   = {lo_q[30:0], div_ge};
    step_hi  = op_q[2] ? div_hi : mul_hi;
    step_lo  = op_q[2] ? div_lo : mul_lo;
    prod     = {step_hi, step_lo};
    prod_s   = neg_q ? (64'd0 - prod) : prod;
    quot_s   = neg_q ? (32'd0 - step_lo) : step_lo;
    rem_s    = rneg_q ? (32'd0 - step_hi) : step_hi;
    if (op_q[2])
      final_res = op_q[1] ? rem_s : quot_s;
    else
      final_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3;
          tag_d = rdIn;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            rd_out_d = rdIn;
            if (div_zero)
              result_d = funct3[1] ? A : 32'hFFFF_FFFF;
            else
              result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = S_CALC;
            cnt_d   = 5'd0;
            hi_d    = 32'd0;
            lo_d    = a_mag;
            opb_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          cnt_d    = 5'd0;
          result_d = final_res;
          rd_out_d = tag_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rstControl) begin
    if (rstControl) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      tag_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rdOut  = rd_out_q;

endmodule
